// File: rtl/hram_pkg.sv
// Shared definitions for the two-port HyperRAM arbiter: FSM encoding,
// default parameters and controller command field widths.
package hram_pkg;

    localparam int unsigned HRAM_TIMEOUT = 15;
    localparam int unsigned HRAM_LEN_W   = 22;
    localparam int unsigned HRAM_ADDR_W  = 32;
    localparam int unsigned HRAM_DATA_W  = 32;
    localparam int unsigned HRAM_BE_W    = 4;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        ISSUE     = ST_ISSUE,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE
    } state_e;

    // Command fields latched toward the controller on a grant
    typedef struct packed {
        logic [HRAM_ADDR_W-1:0] addr;
        logic [HRAM_DATA_W-1:0] wdata;
        logic [HRAM_BE_W-1:0]   be;
    } hram_cmd_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/hram_arbiter_if.sv
// Requester and controller signals of the HyperRAM arbiter; the arbiter
// uses the slave view, requesters/controller (or a bench) the master view.
interface hram_arbiter_if
    import hram_pkg::*;
#(
    parameter int unsigned LEN_W = HRAM_LEN_W
) ();

    logic                   p0_req;
    logic                   p0_we;
    logic [HRAM_ADDR_W-1:0] p0_addr;
    logic [HRAM_DATA_W-1:0] p0_wdata;
    logic [HRAM_BE_W-1:0]   p0_be;
    logic [LEN_W-1:0]       p0_len;
    logic                   p0_gnt;
    logic                   p0_rvalid;
    logic [HRAM_DATA_W-1:0] p0_rdata;
    logic                   p0_done;

    logic                   p1_req;
    logic                   p1_we;
    logic [HRAM_ADDR_W-1:0] p1_addr;
    logic [HRAM_DATA_W-1:0] p1_wdata;
    logic [HRAM_BE_W-1:0]   p1_be;
    logic [LEN_W-1:0]       p1_len;
    logic                   p1_gnt;
    logic                   p1_rvalid;
    logic [HRAM_DATA_W-1:0] p1_rdata;
    logic                   p1_done;

    logic                   timeout_err;
    logic                   rd_req;
    logic                   wr_req;
    logic [HRAM_ADDR_W-1:0] addr;
    logic [HRAM_DATA_W-1:0] wr_d;
    logic [HRAM_BE_W-1:0]   wr_byte_en;
    logic [LEN_W-1:0]       rd_num_dwords;
    logic                   busy;
    logic                   rd_rdy;
    logic [HRAM_DATA_W-1:0] rd_d;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_be, p0_len,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_be, p1_len,
        input  busy, rd_rdy, rd_d,
        output p0_gnt, p0_rvalid, p0_rdata, p0_done,
        output p1_gnt, p1_rvalid, p1_rdata, p1_done,
        output timeout_err, rd_req, wr_req, addr, wr_d, wr_byte_en, rd_num_dwords
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_be, p0_len,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_be, p1_len,
        output busy, rd_rdy, rd_d,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_done,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_done,
        input  timeout_err, rd_req, wr_req, addr, wr_d, wr_byte_en, rd_num_dwords
    );

endinterface

// File: rtl/hram_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not served last.
module hram_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       win_c_o,
    output logic       valid_c_o
);

    always_comb begin
        win_c_o   = 1'b0;
        valid_c_o = |req_i;
        case (req_i)
            2'b01:   win_c_o = 1'b0;
            2'b10:   win_c_o = 1'b1;
            2'b11:   win_c_o = ~last_i;
            default: win_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/hram_arbiter.sv
// Two-port arbiter/sequencer in front of the HyperRAM controller: grants
// round-robin, issues one command pulse, tracks busy and routes read beats.
module hram_arbiter
    import hram_pkg::*;
#(
    parameter int unsigned TIMEOUT = HRAM_TIMEOUT,
    parameter int unsigned LEN_W   = HRAM_LEN_W
) (
    input  logic          hram_clk,
    input  logic          rstn,
    hram_arbiter_if.slave bus
);

    localparam int unsigned      TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e                         state_q, state_d;
    logic                           owner_q, owner_d;
    logic                           last_q, last_d;
    logic [TMR_W-1:0]               timer_q, timer_d;
    hram_cmd_t                      cmd_q, cmd_d;
    logic [LEN_W-1:0]               len_q, len_d;
    logic [1:0]                     gnt_q, gnt_d;
    logic [1:0]                     done_q, done_d;
    logic [1:0]                     rvalid_q, rvalid_d;
    logic [1:0][HRAM_DATA_W-1:0]    rdata_q, rdata_d;
    logic                           tmo_q, tmo_d;
    logic                           rd_req_q, rd_req_d;
    logic                           wr_req_q, wr_req_d;

    logic [1:0]                     req_c;
    logic [1:0]                     req_we_c;
    hram_cmd_t [1:0]                req_cmd_c;
    logic [1:0][LEN_W-1:0]          req_len_c;
    logic                           win_c;
    logic                           win_valid_c;

    assign req_c        = {bus.p1_req, bus.p0_req};
    assign req_we_c     = {bus.p1_we, bus.p0_we};
    assign req_cmd_c[0] = {bus.p0_addr, bus.p0_wdata, bus.p0_be};
    assign req_cmd_c[1] = {bus.p1_addr, bus.p1_wdata, bus.p1_be};
    assign req_len_c[0] = bus.p0_len;
    assign req_len_c[1] = bus.p1_len;

    hram_rr_pick u_pick (
        .req_i     (req_c),
        .last_i    (last_q),
        .win_c_o   (win_c),
        .valid_c_o (win_valid_c)
    );

    // Next-state, timer, command latch and pulse generation
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        timer_d  = timer_q;
        cmd_d    = cmd_q;
        len_d    = len_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        rvalid_d = 2'b00;
        rdata_d  = rdata_q;
        tmo_d    = 1'b0;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;

        // Read beats belong to the owner only while a command is in flight
        if ((state_q == WAIT_BUSY || state_q == WAIT_DONE) && bus.rd_rdy) begin
            rvalid_d = port_onehot(owner_q);
            if (owner_q) rdata_d[1] = bus.rd_d;
            else         rdata_d[0] = bus.rd_d;
        end

        case (state_q)
            IDLE: begin
                if (!bus.busy && win_valid_c) begin
                    owner_d  = win_c;
                    cmd_d    = req_cmd_c[win_c];
                    len_d    = req_len_c[win_c];
                    gnt_d    = port_onehot(win_c);
                    rd_req_d = ~req_we_c[win_c];
                    wr_req_d = req_we_c[win_c];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TMR_LAST) begin
                    done_d  = port_onehot(owner_q);
                    tmo_d   = 1'b1;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.busy) begin
                    done_d  = port_onehot(owner_q);
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last resets to 1 so port 0 wins the first tie
    always_ff @(posedge hram_clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            timer_q  <= '0;
            cmd_q    <= '0;
            len_q    <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
            tmo_q    <= 1'b0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            timer_q  <= timer_d;
            cmd_q    <= cmd_d;
            len_q    <= len_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            tmo_q    <= tmo_d;
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
        end
    end

    assign bus.p0_gnt        = gnt_q[0];
    assign bus.p1_gnt        = gnt_q[1];
    assign bus.p0_done       = done_q[0];
    assign bus.p1_done       = done_q[1];
    assign bus.p0_rvalid     = rvalid_q[0];
    assign bus.p1_rvalid     = rvalid_q[1];
    assign bus.p0_rdata      = rdata_q[0];
    assign bus.p1_rdata      = rdata_q[1];
    assign bus.timeout_err   = tmo_q;
    assign bus.rd_req        = rd_req_q;
    assign bus.wr_req        = wr_req_q;
    assign bus.addr          = cmd_q.addr;
    assign bus.wr_d          = cmd_q.wdata;
    assign bus.wr_byte_en    = cmd_q.be;
    assign bus.rd_num_dwords = len_q;

endmodule

// File: tb/tb_hram_arbiter.sv
// Bench for hram_arbiter: scenario tasks plus randomized rounds checked
// against a transaction-level model of grant order and completion timing.
module tb_hram_arbiter;

    localparam int unsigned TMO = 15;
    localparam int unsigned LW  = 22;
    localparam int unsigned FW  = 68 + LW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    hram_arbiter_if #(.LEN_W(LW)) bus ();

    hram_arbiter #(.TIMEOUT(TMO), .LEN_W(LW)) dut (
        .hram_clk (clk),
        .rstn     (rstn),
        .bus      (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int obs_beats;

    bit              pend [2];
    logic            exp_we [2];
    logic [31:0]     exp_addr [2];
    logic [31:0]     exp_wdata [2];
    logic [3:0]      exp_be [2];
    logic [LW-1:0]   exp_len [2];
    bit              last_m;

    // {p0_gnt,p1_gnt,p0_done,p1_done,timeout_err,p0_rvalid,p1_rvalid,rd_req,wr_req}
    function automatic logic [8:0] obs_ctl();
        return {bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done, bus.timeout_err,
                bus.p0_rvalid, bus.p1_rvalid, bus.rd_req, bus.wr_req};
    endfunction

    function automatic logic [FW-1:0] obs_fld();
        return {bus.addr, bus.wr_d, bus.wr_byte_en, bus.rd_num_dwords};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input logic req, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be, input logic [LW-1:0] len);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a;
            bus.p0_wdata = wd; bus.p0_be = be; bus.p0_len = len;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a;
            bus.p1_wdata = wd; bus.p1_be = be; bus.p1_len = len;
        end
    endtask

    task automatic set_port(input int p, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be, input logic [LW-1:0] len);
        pend[p] = 1'b1;
        exp_we[p] = we; exp_addr[p] = a; exp_wdata[p] = wd; exp_be[p] = be; exp_len[p] = len;
        drive_port(p, 1'b1, we, a, wd, be, len);
    endtask

    task automatic set_random(input int p);
        set_port(p, 1'($urandom), $urandom, $urandom, 4'($urandom), LW'($urandom));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.busy = 1'b0; bus.rd_rdy = 1'b0; bus.rd_d = '0;
        drive_port(0, 1'b0, 1'b0, '0, '0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0, '0, '0);
        pend[0] = 1'b0; pend[1] = 1'b0;
        last_m = 1'b1;
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            n_checks++;
            if (obs_ctl() !== 9'b0) begin
                n_fail++;
                $display("FAIL idle: got %b expected %b", obs_ctl(), 9'b0);
            end
            bus.rd_rdy = 1'b0;
        end
    endtask

    // One grant/complete transaction. Controller raises busy d cycles after the
    // grant cycle for l cycles (never, if d > TMO); beats[k] strobes rd_rdy in
    // cycle k after the grant.
    task automatic round(input int d, input int l, input logic [31:0] beats, input bit seq_data);
        int win, done_k, nbeat;
        bit timed, prev_beat;
        logic [31:0] prev_d, got_d;
        logic [8:0] exp_c;
        logic [FW-1:0] exp_f;
        win       = (pend[0] && pend[1]) ? (last_m ? 0 : 1) : (pend[0] ? 0 : 1);
        timed     = (d > int'(TMO));
        done_k    = timed ? int'(TMO) + 1 : d + l + 1;
        exp_f     = {exp_addr[win], exp_wdata[win], exp_be[win], exp_len[win]};
        obs_beats = 0;
        nbeat     = 0;
        prev_beat = 1'b0;
        prev_d    = '0;
        tick();
        exp_c = '0;
        exp_c[8-win] = 1'b1;
        exp_c[1] = ~exp_we[win];
        exp_c[0] = exp_we[win];
        n_checks++;
        if (obs_ctl() !== exp_c) begin
            n_fail++;
            $display("FAIL grant: got %b expected %b (port %0d)", obs_ctl(), exp_c, win);
        end
        n_checks++;
        if (obs_fld() !== exp_f) begin
            n_fail++;
            $display("FAIL grant_fields: got %h expected %h", obs_fld(), exp_f);
        end
        pend[win] = 1'b0;
        drive_port(win, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom), LW'($urandom));
        for (int k = 0; k <= done_k; k++) begin
            if (k > 0) begin
                tick();
                exp_c = '0;
                if (k == done_k) begin
                    exp_c[6-win] = 1'b1;
                    exp_c[4] = timed;
                end
                if (prev_beat) exp_c[3-win] = 1'b1;
                obs_beats += int'(win ? bus.p1_rvalid : bus.p0_rvalid);
                n_checks++;
                if (obs_ctl() !== exp_c) begin
                    n_fail++;
                    $display("FAIL cycle%0d: got %b expected %b (port %0d)", k, obs_ctl(), exp_c, win);
                end
                if (prev_beat) begin
                    got_d = win ? bus.p1_rdata : bus.p0_rdata;
                    n_checks++;
                    if (got_d !== prev_d) begin
                        n_fail++;
                        $display("FAIL rdata%0d: got %h expected %h", k, got_d, prev_d);
                    end
                end
                n_checks++;
                if (obs_fld() !== exp_f) begin
                    n_fail++;
                    $display("FAIL field_hold%0d: got %h expected %h", k, obs_fld(), exp_f);
                end
            end
            bus.busy   = !timed && (k >= d) && (k < d + l);
            bus.rd_rdy = beats[k];
            bus.rd_d   = seq_data ? 32'h11 * 32'(nbeat + 1) : $urandom;
            if (beats[k]) nbeat++;
            prev_beat  = beats[k] && (k >= 1) && (k <= done_k - 1);
            prev_d     = bus.rd_d;
        end
        last_m = (win == 1);
    endtask

    task automatic test_reset();
        do_reset();
        rstn = 1'b0;
        #1;
        n_checks++;
        if (obs_ctl() !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b expected %b", obs_ctl(), 9'b0);
        end
        n_checks++;
        if ({obs_fld(), bus.p0_rdata, bus.p1_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {obs_fld(), bus.p0_rdata, bus.p1_rdata});
        end
        rstn = 1'b1;
        idle_check(2);
    endtask

    task automatic test_write();
        set_port(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h0, LW'(0));
        round(2, 3, 32'h0, 1'b0);
    endtask

    task automatic test_tie_alternation();
        do_reset();
        set_random(0); set_random(1);
        round(1, 1, 32'h0, 1'b0);
        round(1, 2, 32'h0, 1'b0);
        set_random(0); set_random(1);
        round(2, 1, 32'h0, 1'b0);
        round(1, 1, 32'h0, 1'b0);
    endtask

    task automatic test_read_routing();
        set_port(1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, LW'(3));
        round(1, 4, 32'h7C, 1'b1);
        n_checks++;
        if (obs_beats !== 4) begin
            n_fail++;
            $display("FAIL beat_count: got %0d expected %0d", obs_beats, 4);
        end
        idle_check(2);
    endtask

    task automatic test_timeout();
        set_random(0);
        round(int'(TMO) + 5, 1, 32'h0, 1'b0);
        set_random(1);
        round(2, 2, 32'h0, 1'b0);
    endtask

    task automatic test_busy_hold();
        bus.busy = 1'b1;
        set_random(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (obs_ctl() !== 9'b0) begin
                n_fail++;
                $display("FAIL busy_hold%0d: got %b expected %b", i, obs_ctl(), 9'b0);
            end
        end
        bus.busy = 1'b0;
        round(1, 2, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] exp_f;
        set_port(0, 1'b1, 32'hA5A5_0F0F, 32'h0123_4567, 4'h3, LW'(5));
        exp_f = {32'hA5A5_0F0F, 32'h0123_4567, 4'h3, LW'(5)};
        tick();
        n_checks++;
        if (obs_ctl() !== 9'b1_0000_0001) begin
            n_fail++;
            $display("FAIL mid_grant: got %b expected %b", obs_ctl(), 9'b1_0000_0001);
        end
        pend[0] = 1'b0;
        drive_port(0, 1'b0, 1'b0, '0, '0, '0, '0);
        bus.busy = 1'b0;
        tick();
        bus.busy = 1'b1;
        tick();
        tick();
        n_checks++;
        if (obs_fld() !== exp_f) begin
            n_fail++;
            $display("FAIL mid_fields: got %h expected %h", obs_fld(), exp_f);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({obs_ctl(), obs_fld()} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", {obs_ctl(), obs_fld()});
        end
        bus.busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs_ctl() !== 9'b0) begin
                n_fail++;
                $display("FAIL reset_no_done%0d: got %b expected %b", i, obs_ctl(), 9'b0);
            end
        end
        rstn = 1'b1;
        last_m = 1'b1;
        set_random(0); set_random(1);
        round(1, 1, 32'h0, 1'b0);
        round(1, 1, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] nr;
        for (int it = 0; it < 40; it++) begin
            nr = 2'($urandom);
            for (int p = 0; p < 2; p++)
                if (nr[p] && !pend[p]) set_random(p);
            if (pend[0] || pend[1])
                round(int'($urandom_range(1, TMO + 2)), int'($urandom_range(1, 5)), $urandom, 1'b0);
            else
                idle_check(1);
        end
        while (pend[0] || pend[1]) round(1, 1, 32'h0, 1'b0);
        idle_check(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_tie_alternation();
        test_read_routing();
        test_timeout();
        test_busy_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
